// File: rtl/chip8_pkg.sv
// Shared CHIP-8 core definitions: address/opcode widths, program base and fetch FSM states.
package chip8_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned OP_W   = 16;

  localparam logic [ADDR_W-1:0] PROG_BASE = 12'h200;

  typedef enum logic [2:0] {
    StIdle,
    StHi,
    StLo,
    StCap,
    StValid,
    StFault
  } fetch_state_e;

  // Address arithmetic wraps at the 4 KiB boundary by construction.
  function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] n);
    return a + n;
  endfunction

endpackage

// File: rtl/chip8_pc_next.sv
// Combinational next-PC mux: load beats skip beats step, all with 12-bit wrap.
module chip8_pc_next
  import chip8_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              skip,
  output logic [ADDR_W-1:0] pc_next
);

  always_comb begin
    if (load) begin
      pc_next = load_addr;
    end else if (skip) begin
      pc_next = addr_add(pc, ADDR_W'(4));
    end else begin
      pc_next = addr_add(pc, ADDR_W'(2));
    end
  end

endmodule

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: byte-wise reads from registered-read memory into 16-bit opcodes.
// Optional odd-target fault detection is enabled by defining CHIP8_FETCH_ALIGN_CHECK_EN.
module chip8_fetch
  import chip8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = PROG_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [OP_W-1:0]   opcode,
  output logic [ADDR_W-1:0] op_pc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  input  logic              pc_skip,
  output logic              fault
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] op_pc_q;
  logic [7:0]        hi_q;
  logic [OP_W-1:0]   opcode_q;
  logic              op_valid_q;

  logic              accept;
  logic              load_bad;
  logic [ADDR_W-1:0] pc_accept;

  assign accept = op_valid_q & op_ready;

  chip8_pc_next u_pc_next (
    .pc        (pc_q),
    .load      (pc_load),
    .load_addr (pc_load_addr),
    .skip      (pc_skip),
    .pc_next   (pc_accept)
  );

`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
  logic fault_q;

  assign load_bad = pc_load & pc_load_addr[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (load_bad && state_q != StFault) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign load_bad = 1'b0;
  assign fault    = 1'b0;
`endif

  // Low byte lives at pc+1 while the high byte is in flight and while it is captured.
  always_comb begin
    unique case (state_q)
      StLo, StCap: mem_addr = addr_add(pc_q, ADDR_W'(1));
      default:     mem_addr = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      op_pc_q    <= RESET_PC;
      hi_q       <= 8'h00;
      opcode_q   <= '0;
      op_valid_q <= 1'b0;
    end else if (load_bad && state_q != StFault) begin
      // Misaligned redirect: freeze the PC and park until reset.
      state_q    <= StFault;
      op_valid_q <= 1'b0;
    end else if (accept) begin
      pc_q       <= pc_accept;
      op_valid_q <= 1'b0;
      state_q    <= fetch_en ? StHi : StIdle;
    end else if (pc_load && state_q != StFault) begin
      // Flush: drop any partial or held opcode and restart at the target.
      pc_q       <= pc_load_addr;
      op_valid_q <= 1'b0;
      state_q    <= fetch_en ? StHi : StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (fetch_en) begin
            state_q <= StHi;
          end
        end
        StHi: begin
          state_q <= StLo;
        end
        StLo: begin
          hi_q    <= mem_data;
          state_q <= StCap;
        end
        StCap: begin
          opcode_q   <= {hi_q, mem_data};
          op_pc_q    <= pc_q;
          op_valid_q <= 1'b1;
          state_q    <= StValid;
        end
        StValid: begin
          state_q <= StValid;
        end
        StFault: begin
          state_q <= StFault;
        end
        default: begin
          state_q    <= StIdle;
          op_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign op_valid = op_valid_q;
  assign opcode   = opcode_q;
  assign op_pc    = op_pc_q;

endmodule

// File: tb/tb_chip8_fetch.sv
// Scoreboard bench for chip8_fetch: directed redirects, skips, flushes and address wrap.
module tb_chip8_fetch;

  typedef struct packed {
    logic [15:0] op;
    logic [11:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] opcode;
  logic [11:0] op_pc;
  logic        pc_load;
  logic [11:0] pc_load_addr;
  logic        pc_skip;
  logic        fault;

  logic [7:0]  mem [4096];
  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  int          lat;

  chip8_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .opcode       (opcode),
    .op_pc        (op_pc),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .pc_skip      (pc_skip),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  // Registered-read program memory.
  always @(posedge clk) mem_data <= mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted opcode must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && op_valid && op_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_accept: got %h@%h want none", opcode, op_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("accept_opcode", {16'h0, opcode}, {16'h0, e.op});
        check("accept_op_pc", {20'h0, op_pc}, {20'h0, e.pc});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!op_valid && n < 50) begin
      step(1);
      n++;
    end
    if (!op_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: got timeout after %0d cycles want op_valid", n);
    end
  endtask

  task automatic expect_op(input logic [15:0] op, input logic [11:0] pc);
    exp_t e;
    e.op = op;
    e.pc = pc;
    sb_q.push_back(e);
  endtask

  task automatic accept(input logic skip, input logic load, input logic [11:0] addr);
    int n;
    wait_valid(n);
    op_ready     = 1'b1;
    pc_skip      = skip;
    pc_load      = load;
    pc_load_addr = addr;
    step(1);
    op_ready = 1'b0;
    pc_skip  = 1'b0;
    pc_load  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = i[7:0];
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    mem[12'h300] = 8'hA1; mem[12'h301] = 8'hB2; mem[12'h302] = 8'hC3;
    mem[12'h400] = 8'hC3; mem[12'h401] = 8'h5E;
    mem[12'hFFE] = 8'hAB; mem[12'hFFF] = 8'hCD;
    mem[12'h000] = 8'h6F; mem[12'h001] = 8'h70;

    rst = 1'b1; fetch_en = 1'b0; op_ready = 1'b0;
    pc_load = 1'b0; pc_load_addr = 12'h000; pc_skip = 1'b0;
    step(2);
    check("rst_op_valid", {31'h0, op_valid}, 32'h0);
    check("rst_mem_addr", {20'h0, mem_addr}, 32'h200);
    check("rst_opcode", {16'h0, opcode}, 32'h0);
    check("rst_op_pc", {20'h0, op_pc}, 32'h200);
    check("rst_fault", {31'h0, fault}, 32'h0);

    rst = 1'b0; fetch_en = 1'b1;
    wait_valid(lat);
    check("first_latency", lat, 32'd4);
    expect_op(16'h1234, 12'h200);
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", {opcode, op_pc, 4'h0}, {16'h1234, 12'h200, 4'h0});
      check("stall_mem_addr", {20'h0, mem_addr}, 32'h200);
      step(1);
    end
    accept(1'b0, 1'b0, 12'h000);
    check("pc_after_accept", {20'h0, mem_addr}, 32'h202);

    expect_op(16'h0203, 12'h202);
    wait_valid(lat);
    check("b2b_latency", lat, 32'd3);
    accept(1'b0, 1'b0, 12'h000);

    expect_op(16'h0405, 12'h204);
    accept(1'b1, 1'b0, 12'h000);
    expect_op(16'h0809, 12'h208);
    accept(1'b1, 1'b1, 12'h300);
    expect_op(16'hA1B2, 12'h300);
    accept(1'b0, 1'b0, 12'h000);

    // Flush while the 0x302 fetch sits in the low-byte phase.
    step(1);
    pc_load = 1'b1; pc_load_addr = 12'h400;
    step(1);
    pc_load = 1'b0;
    check("flush_op_valid", {31'h0, op_valid}, 32'h0);
    check("flush_mem_addr", {20'h0, mem_addr}, 32'h400);
    expect_op(16'hC35E, 12'h400);
    wait_valid(lat);
    check("flush_latency", lat, 32'd3);
    accept(1'b0, 1'b0, 12'h000);

    pc_load = 1'b1; pc_load_addr = 12'hFFE;
    step(1);
    pc_load = 1'b0;
    expect_op(16'hABCD, 12'hFFE);
    accept(1'b0, 1'b0, 12'h000);
    expect_op(16'h6F70, 12'h000);

`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
    accept(1'b0, 1'b1, 12'h301);
    check("fault_set", {31'h0, fault}, 32'h1);
    check("fault_op_valid", {31'h0, op_valid}, 32'h0);
    check("fault_mem_addr", {20'h0, mem_addr}, 32'h000);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        seen |= op_valid;
        step(1);
      end
      check("fault_sticky_valid", {31'h0, seen}, 32'h0);
      check("fault_sticky", {31'h0, fault}, 32'h1);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("fault_cleared", {31'h0, fault}, 32'h0);
    check("fault_rst_mem_addr", {20'h0, mem_addr}, 32'h200);
`else
    accept(1'b0, 1'b1, 12'h301);
    expect_op(16'hB2C3, 12'h301);
    accept(1'b0, 1'b1, 12'hFFF);
    expect_op(16'hCD6F, 12'hFFF);
    accept(1'b0, 1'b0, 12'h000);
    expect_op(16'h7002, 12'h001);
    accept(1'b0, 1'b1, 12'hFFE);
    expect_op(16'hABCD, 12'hFFE);
    accept(1'b1, 1'b0, 12'h000);
    // Drop the enable mid-fetch: the opcode still completes, then the unit idles.
    fetch_en = 1'b0;
    expect_op(16'h0203, 12'h002);
    wait_valid(lat);
    check("no_abort_latency", lat, 32'd3);
    accept(1'b0, 1'b0, 12'h000);
    step(5);
    check("idle_op_valid", {31'h0, op_valid}, 32'h0);
    check("idle_mem_addr", {20'h0, mem_addr}, 32'h004);
    check("no_fault", {31'h0, fault}, 32'h0);
`endif

    step(2);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/chip8_fetch.md
# chip8_fetch

Instruction fetch unit for the CHIP-8 core. It is the initiator on the byte-wide, registered-read program memory port: it issues 12-bit addresses, takes the returned bytes one cycle later, and assembles big-endian 16-bit opcodes. Opcodes go to the decoder over a valid/ready handshake. It owns the program counter, and the decoder redirects it through load and skip requests.

## Interface
- RESET_PC, default 12'h200: PC value after reset (program load base).
- clk  in  1: single clock, all logic on rising edge.
- rst  in  1: reset, synchronous, active-high.
- fetch_en  in  1: run enable; fetching starts or continues only while high.
- mem_addr  out  12: byte address to program memory, combinational from state and fetch pointer.
- mem_data  in  8: memory read data, valid the cycle after mem_addr is presented.
- op_valid  out  1: opcode/op_pc hold a complete instruction.
- op_ready  in  1: decoder accepts the instruction.
- opcode  out  16: {mem[pc], mem[pc+1]}.
- op_pc  out  12: address of opcode's high byte.
- pc_load  in  1: redirect the PC to pc_load_addr.
- pc_load_addr  in  12: redirect target.
- pc_skip  in  1: skip the next instruction (conditional-skip opcodes). Honoured only on the accept cycle.
- fault  out  1: alignment fault, sticky (see Configuration).

## Operation
- States:
  - S_IDLE: mem_addr=pc.
  - S_HI: mem_addr=pc.
  - S_LO: mem_addr=pc+1, capture high byte.
  - S_CAP: mem_addr=pc+1, capture low byte.
  - S_VALID: op_valid=1.
  - S_FAULT: op_valid=0.
- Transitions:
  - S_IDLE→S_HI when fetch_en=1.
  - S_HI→S_LO→S_CAP→S_VALID unconditionally.
- Accept is op_valid & op_ready. On accept, next pc is chosen in priority order:
  - pc_load: pc_load_addr.
  - pc_skip: pc+4.
  - otherwise: pc+2.
- After accept, go to S_HI if fetch_en=1, else S_IDLE.
- pc_load outside an accept cycle, in any state except S_FAULT, is a flush:
  - pc ← pc_load_addr.
  - Any partial fetch is discarded and op_valid drops next cycle.
  - Next state is S_HI if fetch_en=1, else S_IDLE.
- pc_skip outside an accept cycle is ignored.
- If pc_load and pc_skip are high together, load wins.
- Deasserting fetch_en mid-fetch does not abort. The current opcode completes and is held in S_VALID until accepted.
- opcode and op_pc stay stable while op_valid=1 and op_ready=0.
- Arithmetic:
  - All PC arithmetic is modulo 4096, 12-bit wrap.
  - pc=12'hFFF fetches its low byte from 12'h000.
  - pc=12'hFFE with skip gives 12'h002.
- Reset values:
  - state S_IDLE.
  - pc=RESET_PC.
  - mem_addr=RESET_PC.
  - op_valid=0.
  - opcode=16'h0000.
  - op_pc=RESET_PC.
  - fault=0.
- Reset mid-fetch or while op_valid=1 discards everything and takes effect at the next edge.

## Timing
- Memory has 1-cycle registered read latency. The unit never presents a new address expecting same-cycle data.
- Latency from entering S_HI to op_valid=1 is 3 cycles.
- Back-to-back instructions with op_ready held high: one opcode every 4 cycles (accept cycle plus S_HI, S_LO, S_CAP).
- A flush during S_LO/S_CAP yields the first valid opcode from the new target 3 cycles after S_HI is re-entered.
- op_valid is registered and has no combinational path from op_ready.

## Configuration
- CHIP8_FETCH_ALIGN_CHECK_EN defined:
  - pc_load with pc_load_addr[0]=1, on accept or as a flush, sets fault=1 and enters S_FAULT.
  - The PC is not updated.
  - The unit stays in S_FAULT with op_valid=0 and mem_addr=pc until rst.
- Undefined:
  - Odd targets load normally and fetch byte-wise from the odd address.
  - fault is tied 0 and S_FAULT is unreachable.

## Structure
- Shared package chip8_pkg holds:
  - ADDR_W=12.
  - PROG_BASE=12'h200 (RESET_PC default).
  - OP_W=16.
  - The fetch state enum.
- The unit body is a single module. One natural sub-module is chip8_pc_next, a combinational next-PC mux (load/skip/step, 12-bit wrap), reusable by the execute stage for call/return.

## Test plan
- Reset, fetch_en=1, memory 0x200=0x12, 0x201=0x34, op_ready=1 → op_valid rises 3 cycles after S_HI, opcode=16'h1234, op_pc=12'h200, next op_pc=12'h202.
- op_ready=0 for 5 cycles while op_valid=1 → opcode/op_pc stable and mem_addr constant. Accept on cycle 6 → pc=12'h202.
- Accept with pc_skip=1 at op_pc=12'h204 → next op_pc=12'h208. Accept with pc_load=1 and pc_skip=1, target 12'h300 → next op_pc=12'h300.
- pc_load=1 to 12'h400 during S_LO → partial opcode discarded and next opcode reports op_pc=12'h400.
- Load 12'hFFE with memory 0xFFE=0xAB, 0xFFF=0xCD → opcode=16'hABCD. On accept, next op_pc=12'h000.
- With CHIP8_FETCH_ALIGN_CHECK_EN, pc_load to 12'h301 → fault=1 next cycle and op_valid stays 0 until rst. Without the macro, opcode from 12'h301/12'h302 is returned and fault=0.
